axis_pattern_gen: RTL and testbench
===================================

# axis_pattern_gen

AXI4-Stream traffic source that emits a configurable number of fixed-length packets carrying a deterministic incrementing byte pattern. It drives the slave stream port of the in-fabric stream processors (for example, the byte inverter) so that loopback and throughput can be exercised without host DMA. A downstream checker can predict every byte from SEED alone.

## Interface
Parameters:
- LEN_WIDTH, 16: width of PKT_BEATS and GAP_CYCLES.
- CNT_WIDTH, 16: width of NUM_PKTS.

Ports (reset is asynchronous and active-low; CLK is the single clock):
- CLK  in  1  sole clock.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request; honoured only in IDLE.
- NUM_PKTS  in  CNT_WIDTH  packets per run; latched on accepted START.
- PKT_BEATS  in  LEN_WIDTH  beats per packet; latched; 0 treated as 1.
- GAP_CYCLES  in  LEN_WIDTH  idle cycles between packets; latched.
- SEED  in  8  value of byte 0 of the run; latched.
- M_AXIS_TDATA  out  64  beat data.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  last beat of packet.
- BUSY  out  1  high from the cycle after an accepted START until completion.
- DONE  out  1  one-cycle completion pulse.
- BEATS_SENT  out  32  handshaken beats this run; cleared on accepted START; wraps modulo 2^32.

## Operation
- States: IDLE, SEND, GAP, FIN.
- IDLE: on START, latch the inputs, zero the beat, packet and BEATS_SENT counters, and load byte base B=SEED.
  - If NUM_PKTS=0, go to FIN.
  - Otherwise go to SEND.
- SEND: TVALID=1. Byte lane i (bits 8i+7:8i) = (B+i) mod 256. TLAST=1 when beat index = PKT_BEATS-1.
  - On handshake (TVALID&TREADY): increment BEATS_SENT and set B += 8 mod 256.
  - Non-last beat: advance to the next beat.
  - Last beat, more packets remain: go to GAP, or stay in SEND if GAP_CYCLES=0.
  - Last beat of the final packet: go to FIN.
- GAP: TVALID=0 for exactly GAP_CYCLES cycles, then SEND.
- FIN: DONE=1 for one cycle, then IDLE.
- The byte pattern is continuous across packet boundaries. B never resets within a run.
- START outside IDLE is ignored. Latched values never change mid-run.
- All outputs are registered.

## Timing
- Reset values: TVALID=0, TLAST=0, TDATA=0, BUSY=0, DONE=0, BEATS_SENT=0, state IDLE.
- Reset mid-run: outputs go to reset values immediately (asynchronous); no partial packet is completed.
- START accepted at cycle t: BUSY=1 and TVALID=1 with the first beat at t+1.
- Full throughput: with TREADY held high, one beat per cycle; no bubbles within a packet, or between packets when GAP_CYCLES=0.
- Backpressure: while TVALID=1 and TREADY=0, TDATA and TLAST hold stable. TVALID never drops without a handshake.
- Last packet: final handshake at cycle h gives TVALID=0, DONE=1, BUSY=1 at h+1, then BUSY=0 at h+2.
- Last beat of a non-final packet handshaken at cycle h with GAP_CYCLES=G>0: TVALID=0 during h+1..h+G, next beat at h+G+1.
- NUM_PKTS=0: START at t gives DONE at t+1 and no beats.
- While TVALID=0, TDATA holds its last value.

## Test plan
- Reset, then START with NUM_PKTS=1, PKT_BEATS=2, SEED=0x00, GAP=0, TREADY=1 -> beats 0x0706050403020100 then 0x0F0E0D0C0B0A0908 (TLAST=1) on consecutive cycles; DONE one cycle later; BEATS_SENT=2.
- NUM_PKTS=3, PKT_BEATS=4, SEED=0xF8, GAP=0, TREADY=1 -> 12 back-to-back beats; first beat 0x07060504030201F8-style wrap is wrong, required first beat is 0xFFFEFDFCFBFAF9F8, second 0x0706050403020100; TLAST on beats 4, 8 and 12.
- Same configuration with TREADY randomly low about 50% of cycles -> TDATA and TLAST stable while stalled; sequence identical to the previous case; BEATS_SENT=12.
- NUM_PKTS=2, PKT_BEATS=1, GAP=3 -> exactly 3 TVALID=0 cycles between the two beats; PKT_BEATS=0 behaves as 1.
- START pulsed while BUSY is ignored. NUM_PKTS=0 gives DONE at t+1 with no TVALID. RESET_N asserted mid-packet clears TVALID, BUSY and BEATS_SENT immediately; the next START restarts from SEED.

Source files
------------

// File: rtl/axis_pattern_gen.sv
// Purpose : AXI4-Stream source emitting NUM_PKTS packets of PKT_BEATS beats with an incrementing byte pattern seeded by SEED.
// Latency : first beat on the cycle after an accepted START; one beat per cycle while TREADY is high.
// Backpres: TDATA/TLAST held stable while TVALID=1 and TREADY=0; TVALID only drops after a handshake.
//
// Ports:
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   START                        run request, ignored unless idle
//   NUM_PKTS/PKT_BEATS/GAP_CYCLES/SEED  run configuration, captured on an accepted START
//   M_AXIS_TDATA/TVALID/TREADY/TLAST    AXI4-Stream master
//   BUSY, DONE, BEATS_SENT       run status
module axis_pattern_gen #(
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic [CNT_WIDTH-1:0] NUM_PKTS,
  input  logic [LEN_WIDTH-1:0] PKT_BEATS,
  input  logic [LEN_WIDTH-1:0] GAP_CYCLES,
  input  logic [7:0]           SEED,
  output logic [63:0]          M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic                 M_AXIS_TLAST,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [31:0]          BEATS_SENT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [LEN_WIDTH-1:0] L_ONE = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_num_pkts;
  logic [LEN_WIDTH-1:0] r_pkt_beats;
  logic [LEN_WIDTH-1:0] r_gap;
  logic [7:0]           r_base;
  logic [LEN_WIDTH-1:0] r_beat_idx;
  logic [CNT_WIDTH-1:0] r_pkt_cnt;
  logic [LEN_WIDTH-1:0] r_gap_cnt;
  logic [63:0]          r_tdata;
  logic                 r_tvalid;
  logic                 r_tlast;
  logic                 r_busy;
  logic                 r_done;
  logic [31:0]          r_beats_sent;

  logic                 w_hs;
  logic [7:0]           w_base_nxt;
  logic [LEN_WIDTH-1:0] w_beat_nxt;
  logic                 w_next_is_last;
  logic                 w_final_pkt;
  logic                 w_pkt_single;

  // Lane i carries b+i; the 8-bit add wraps naturally.
  function automatic logic [63:0] f_pattern(input logic [7:0] b);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p[8*i +: 8] = b + 8'(i);
    end
    return p;
  endfunction

  assign w_hs           = r_tvalid & M_AXIS_TREADY;
  assign w_base_nxt     = r_base + 8'd8;
  assign w_beat_nxt     = r_beat_idx + L_ONE;
  assign w_next_is_last = (w_beat_nxt == (r_pkt_beats - L_ONE));
  assign w_final_pkt    = (r_pkt_cnt == (r_num_pkts - C_ONE));
  assign w_pkt_single   = (r_pkt_beats == L_ONE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_num_pkts   <= '0;
      r_pkt_beats  <= '0;
      r_gap        <= '0;
      r_base       <= '0;
      r_beat_idx   <= '0;
      r_pkt_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_beats_sent <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_num_pkts   <= NUM_PKTS;
            r_pkt_beats  <= (PKT_BEATS == '0) ? L_ONE : PKT_BEATS;
            r_gap        <= GAP_CYCLES;
            r_base       <= SEED;
            r_beat_idx   <= '0;
            r_pkt_cnt    <= '0;
            r_beats_sent <= '0;
            r_busy       <= 1'b1;
            if (NUM_PKTS == '0) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              // First beat is presented straight from the inputs so it
              // appears on the very next cycle.
              r_tvalid <= 1'b1;
              r_tdata  <= f_pattern(SEED);
              r_tlast  <= (PKT_BEATS <= L_ONE);
              r_state  <= S_SEND;
            end
          end
        end

        S_SEND: begin
          if (w_hs) begin
            r_beats_sent <= r_beats_sent + 32'd1;
            r_base       <= w_base_nxt;
            if (!r_tlast) begin
              r_beat_idx <= w_beat_nxt;
              r_tdata    <= f_pattern(w_base_nxt);
              r_tlast    <= w_next_is_last;
            end else if (w_final_pkt) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_FIN;
            end else begin
              r_beat_idx <= '0;
              r_pkt_cnt  <= r_pkt_cnt + C_ONE;
              if (r_gap == '0) begin
                r_tdata <= f_pattern(w_base_nxt);
                r_tlast <= w_pkt_single;
              end else begin
                // TDATA keeps the last beat during the gap.
                r_tvalid  <= 1'b0;
                r_tlast   <= 1'b0;
                r_gap_cnt <= r_gap;
                r_state   <= S_GAP;
              end
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == L_ONE) begin
            r_tvalid <= 1'b1;
            r_tdata  <= f_pattern(r_base);
            r_tlast  <= w_pkt_single;
            r_state  <= S_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - L_ONE;
          end
        end

        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign BEATS_SENT    = r_beats_sent;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Purpose : self-checking bench for axis_pattern_gen against a byte-stream reference model.
// Latency : checks first beat one cycle after START and DONE one cycle after the final handshake.
// Backpres: drives random TREADY and checks TDATA/TLAST stability while stalled.
module tb_axis_pattern_gen;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [15:0] NUM_PKTS;
  logic [15:0] PKT_BEATS;
  logic [15:0] GAP_CYCLES;
  logic [7:0]  SEED;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic        BUSY;
  logic        DONE;
  logic [31:0] BEATS_SENT;

  int n_checks = 0;
  int n_errors = 0;

  axis_pattern_gen #(.LEN_WIDTH(16), .CNT_WIDTH(16)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .START         (START),
    .NUM_PKTS      (NUM_PKTS),
    .PKT_BEATS     (PKT_BEATS),
    .GAP_CYCLES    (GAP_CYCLES),
    .SEED          (SEED),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .BEATS_SENT    (BEATS_SENT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the run is one continuous byte stream starting at seed;
  // beat k carries bytes seed+8k .. seed+8k+7 (mod 256).
  function automatic logic [63:0] exp_data(input logic [7:0] seed, input int k);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d[8*i +: 8] = 8'((int'(seed) + 8 * k + i) % 256);
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int num, input int beats, input int gap,
                     input logic [7:0] seed, input bit rnd, input bit poke);
    int   be;
    int   total;
    int   idx;
    int   zeros;
    int   cyc;
    int   exp_zeros;
    bit   prev_stall;
    bit   new_beat;
    bit   fin;
    bit   rdy;
    logic [63:0] prev_d;
    logic        prev_l;

    be         = (beats == 0) ? 1 : beats;
    total      = num * be;
    idx        = 0;
    zeros      = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    new_beat   = 1'b1;
    fin        = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;

    NUM_PKTS      = 16'(num);
    PKT_BEATS     = 16'(beats);
    GAP_CYCLES    = 16'(gap);
    SEED          = seed;
    START         = 1'b1;
    M_AXIS_TREADY = 1'b1;
    tick();
    START = 1'b0;
    // Scramble the configuration inputs: the run must use the captured values.
    NUM_PKTS   = 16'($urandom);
    PKT_BEATS  = 16'($urandom);
    GAP_CYCLES = 16'($urandom);
    SEED       = 8'($urandom);

    chk("busy_after_start", 64'(BUSY), 64'(1));
    if (num == 0) begin
      chk("zero_pkts_done", 64'(DONE), 64'(1));
      chk("zero_pkts_tvalid", 64'(M_AXIS_TVALID), 64'(0));
      tick();
      chk("zero_pkts_busy_clr", 64'(BUSY), 64'(0));
      chk("zero_pkts_done_clr", 64'(DONE), 64'(0));
      chk("zero_pkts_beats", 64'(BEATS_SENT), 64'(0));
      chk("zero_pkts_tvalid2", 64'(M_AXIS_TVALID), 64'(0));
      return;
    end
    chk("tvalid_after_start", 64'(M_AXIS_TVALID), 64'(1));

    while (!fin && cyc < 500) begin
      chk("beats_sent", 64'(BEATS_SENT), 64'(idx));
      if (prev_stall) begin
        chk("stall_tvalid", 64'(M_AXIS_TVALID), 64'(1));
        chk("stall_tdata", M_AXIS_TDATA, prev_d);
        chk("stall_tlast", 64'(M_AXIS_TLAST), 64'(prev_l));
      end
      if (M_AXIS_TVALID) begin
        if (new_beat) begin
          exp_zeros = (idx > 0 && (idx % be) == 0) ? gap : 0;
          chk("idle_cycles_before_beat", 64'(zeros), 64'(exp_zeros));
        end
        chk("beat_overrun", 64'(idx < total), 64'(1));
        chk("tdata", M_AXIS_TDATA, exp_data(seed, idx));
        chk("tlast", 64'(M_AXIS_TLAST), 64'((idx % be) == be - 1));
        chk("done_while_valid", 64'(DONE), 64'(0));
        rdy           = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        M_AXIS_TREADY = rdy;
        prev_d        = M_AXIS_TDATA;
        prev_l        = M_AXIS_TLAST;
        new_beat      = 1'b0;
        prev_stall    = !rdy;
        if (rdy) begin
          idx++;
          zeros    = 0;
          new_beat = 1'b1;
        end
      end else begin
        prev_stall    = 1'b0;
        M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        chk("tdata_hold_idle", M_AXIS_TDATA, exp_data(seed, idx - 1));
        if (idx == total) begin
          chk("fin_done", 64'(DONE), 64'(1));
          chk("fin_busy", 64'(BUSY), 64'(1));
          chk("fin_beats_sent", 64'(BEATS_SENT), 64'(total));
          fin = 1'b1;
        end else begin
          zeros++;
          chk("done_early", 64'(DONE), 64'(0));
          chk("busy_in_gap", 64'(BUSY), 64'(1));
        end
      end
      START = (poke && cyc == 2) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    START = 1'b0;
    chk("run_completed", 64'(fin), 64'(1));
    chk("post_busy_clr", 64'(BUSY), 64'(0));
    chk("post_done_clr", 64'(DONE), 64'(0));
    chk("post_tvalid", 64'(M_AXIS_TVALID), 64'(0));
    chk("post_beats_sent", 64'(BEATS_SENT), 64'(total));
    tick();
  endtask

  initial begin
    RESET_N       = 1'b0;
    START         = 1'b0;
    NUM_PKTS      = '0;
    PKT_BEATS     = '0;
    GAP_CYCLES    = '0;
    SEED          = '0;
    M_AXIS_TREADY = 1'b0;
    #12;
    chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
    chk("rst_tlast", 64'(M_AXIS_TLAST), 64'(0));
    chk("rst_tdata", M_AXIS_TDATA, 64'h0);
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_beats_sent", 64'(BEATS_SENT), 64'(0));
    tick();
    RESET_N = 1'b1;
    tick();

    // Single two-beat packet from seed 0.
    run(1, 2, 0, 8'h00, 1'b0, 1'b0);
    chk("literal_beat0", exp_data(8'h00, 0), 64'h0706050403020100);

    // Three packets back to back, byte pattern wraps through 0xFF.
    run(3, 4, 0, 8'hF8, 1'b0, 1'b0);
    chk("literal_wrap", exp_data(8'hF8, 0), 64'hFFFEFDFCFBFAF9F8);

    // Same configuration under random backpressure.
    run(3, 4, 0, 8'hF8, 1'b1, 1'b0);

    // Inter-packet gaps, single-beat packets, and PKT_BEATS=0 acting as 1.
    run(2, 1, 3, 8'h40, 1'b0, 1'b0);
    run(2, 0, 3, 8'h33, 1'b1, 1'b0);
    run(4, 3, 1, 8'hA7, 1'b1, 1'b0);

    // START pulsed mid-run must be ignored.
    run(2, 3, 2, 8'h10, 1'b1, 1'b1);

    // Empty run.
    run(0, 5, 0, 8'h55, 1'b0, 1'b0);

    // Reset in the middle of a packet.
    NUM_PKTS      = 16'd3;
    PKT_BEATS     = 16'd4;
    GAP_CYCLES    = 16'd0;
    SEED          = 8'h5A;
    M_AXIS_TREADY = 1'b1;
    START         = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", 64'(BUSY), 64'(1));
    RESET_N = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
    chk("midrst_busy", 64'(BUSY), 64'(0));
    chk("midrst_beats_sent", 64'(BEATS_SENT), 64'(0));
    chk("midrst_tlast", 64'(M_AXIS_TLAST), 64'(0));
    chk("midrst_tdata", M_AXIS_TDATA, 64'h0);
    tick();
    RESET_N = 1'b1;
    tick();
    run(3, 4, 0, 8'h5A, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
